// File: rtl/banked_init_sram.sv
// banked_init_sram: address-interleaved, bit-masked single-port SRAM with a
// valid/ready request port, fixed-latency read response (optional output
// register) and a hardware sequencer that fills every row with INIT_VALUE.
module banked_init_sram #(
  parameter int               WIDTH         = 128,
  parameter int               NUM_ROWS      = 4096,
  parameter int               NUM_BANKS     = 4,
  parameter int               OUT_REG       = 0,
  parameter int               INIT_ON_RESET = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
  localparam int              AddressWidth  = $clog2(NUM_ROWS)
) (
  input  logic                    CLK,
  input  logic                    RSTB,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [WIDTH-1:0]        req_data,
  input  logic [WIDTH-1:0]        req_mask,
  output logic                    rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  input  logic                    init_start,
  output logic                    init_busy
);

  localparam int BankBits = $clog2(NUM_BANKS);
  localparam int BankRows = NUM_ROWS / NUM_BANKS;
  // Widths clamped to 1 so a single bank or single-row bank still elaborates.
  localparam int BankSelW = (BankBits > 0) ? BankBits : 1;
  localparam int RowW     = (BankRows > 1) ? $clog2(BankRows) : 1;

  localparam logic [RowW-1:0]         LastRow    = RowW'(BankRows - 1);
  localparam logic [AddressWidth:0]   NumRowsExt = (AddressWidth + 1)'(NUM_ROWS);

  localparam logic [0:0] StReady = 1'b0;
  localparam logic [0:0] StInit  = 1'b1;

  // Parameter sanity, evaluated at elaboration time only.
  if (NUM_ROWS % NUM_BANKS != 0) begin : g_bad_rows
    $error("banked_init_sram: NUM_ROWS must be a multiple of NUM_BANKS");
  end
  if ((NUM_BANKS < 1) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_bad_banks
    $error("banked_init_sram: NUM_BANKS must be a power of two");
  end

  logic [0:0]          state_q, state_d;
  logic [RowW-1:0]     init_cnt_q, init_cnt_d;
  logic                ready_q;
  logic                init_active;
  logic                accept;
  logic                rd_accept;
  logic [BankSelW-1:0] req_bank;
  logic [RowW-1:0]     req_row;
  logic                req_in_range;
  logic [WIDTH-1:0]    bank_rdata [NUM_BANKS];
  logic [WIDTH-1:0]    rd_word;
  logic [WIDTH-1:0]    rd_next;
  logic                s1_valid_q;
  logic [WIDTH-1:0]    s1_data_q;

  assign init_active  = (state_q == StInit);
  assign accept       = req_valid & ready_q;
  assign rd_accept    = accept & ~req_we;
  // Low address bits pick the bank, the rest select the row inside it.
  assign req_bank     = (NUM_BANKS > 1) ? req_addr[BankSelW-1:0] : '0;
  assign req_row      = RowW'(req_addr >> BankBits);
  assign req_in_range = ({1'b0, req_addr} < NumRowsExt);

  // Next-state logic: INIT walks every bank row once, READY waits for init_start.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == StInit) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LastRow) begin
        state_d    = StReady;
        init_cnt_d = '0;
      end
    end else if (init_start) begin
      state_d    = StInit;
      init_cnt_d = '0;
    end
  end

  // Control state; req_ready is registered so it stays low throughout reset.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
      state_q    <= (INIT_ON_RESET != 0) ? StInit : StReady;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= (state_d == StReady);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem_q [BankRows];
    logic             bank_sel;
    logic             wr_en;
    logic [RowW-1:0]  wr_row;
    logic [WIDTH-1:0] wr_data;

    assign bank_sel = accept && (req_bank == BankSelW'(b));

    // Write port: the init sweep hits all banks at once, requests only this bank.
    always_comb begin
      wr_en   = init_active || (bank_sel && req_we && req_in_range);
      wr_row  = init_active ? init_cnt_q : req_row;
      wr_data = init_active ? INIT_VALUE
                            : ((req_data & ~req_mask) | (mem_q[req_row] & req_mask));
    end

    // Storage array.
    always_ff @(posedge CLK) begin
      // NOTE: the array has no reset; contents are defined only by init or writes.
      if (wr_en) mem_q[wr_row] <= wr_data;
    end

    // Unselected banks contribute zero, so the bank outputs can simply be OR-ed.
    assign bank_rdata[b] = (bank_sel && !req_we) ? mem_q[req_row] : '0;
  end

  // Merge bank read data; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) rd_word = rd_word | bank_rdata[b];
    rd_next = req_in_range ? rd_word : '0;
  end

  // First read stage: captures row contents at the acceptance edge and holds
  // them until the next read, independent of the FSM.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_accept;
      if (rd_accept) s1_data_q <= rd_next;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;

    // Optional output stage; data only moves when a response is in flight.
    always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_data_q;
  end else begin : g_no_out_reg
    assign rsp_valid = s1_valid_q;
    assign rsp_data  = s1_data_q;
  end

  assign req_ready = ready_q;
  assign init_busy = init_active;

endmodule

// File: tb/tb_banked_init_sram.sv
// Scoreboard bench: two instances (OUT_REG=0 and OUT_REG=1) share stimulus;
// a behavioural row array predicts reads, a per-instance queue holds the
// expected responses with their due cycle, and a monitor compares them.
module tb_banked_init_sram;

  localparam int          W         = 32;
  localparam int          ROWS      = 16;
  localparam int          BANKS     = 4;
  localparam int          BANK_ROWS = ROWS / BANKS;
  localparam logic [W-1:0] INIT_VAL = 32'h5A5A_0F0F;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_we = 1'b0;
  logic         init_start = 1'b0;
  logic [3:0]   req_addr = '0;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] req_mask = '0;

  logic         ready0, ready1, rv0, rv1, busy0, busy1;
  logic [W-1:0] rd0, rd1;

  banked_init_sram #(
    .WIDTH(W), .NUM_ROWS(ROWS), .NUM_BANKS(BANKS), .OUT_REG(0),
    .INIT_ON_RESET(1), .INIT_VALUE(INIT_VAL)
  ) dut0 (
    .CLK(clk), .RSTB(rstb), .req_valid(req_valid), .req_ready(ready0),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rv0), .rsp_data(rd0), .init_start(init_start), .init_busy(busy0)
  );

  banked_init_sram #(
    .WIDTH(W), .NUM_ROWS(ROWS), .NUM_BANKS(BANKS), .OUT_REG(1),
    .INIT_ON_RESET(1), .INIT_VALUE(INIT_VAL)
  ) dut1 (
    .CLK(clk), .RSTB(rstb), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rv1), .rsp_data(rd1), .init_start(init_start), .init_busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  exp_t         e0, e1;
  logic [W-1:0] model [ROWS];
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;
  int           init_left = BANK_ROWS;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor: compares each presented response against the queue head.
  always @(negedge clk) begin
    if (rstb) begin
      if (rv0) begin
        if (q0.size() == 0) check("rsp0_unexpected", W'(rv0), '0);
        else begin
          e0 = q0.pop_front();
          check("rsp0_cycle", W'(cyc), W'(e0.due));
          check("rsp0_data", rd0, e0.data);
          last0 = e0.data;
        end
      end else begin
        check("rsp0_hold", rd0, last0);
        if (q0.size() > 0 && q0[0].due < cyc) begin
          check("rsp0_missing", W'(rv0), W'(1));
          void'(q0.pop_front());
        end
      end
      if (rv1) begin
        if (q1.size() == 0) check("rsp1_unexpected", W'(rv1), '0);
        else begin
          e1 = q1.pop_front();
          check("rsp1_cycle", W'(cyc), W'(e1.due));
          check("rsp1_data", rd1, e1.data);
          last1 = e1.data;
        end
      end else begin
        check("rsp1_hold", rd1, last1);
        if (q1.size() > 0 && q1[0].due < cyc) begin
          check("rsp1_missing", W'(rv1), W'(1));
          void'(q1.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; called #1 after a posedge, returns #1 after the next.
  task automatic drive(input logic v, input logic we, input logic [3:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] m, input logic st);
    logic exp_rdy;
    int   e;
    req_valid = v; req_we = we; req_addr = a; req_data = d; req_mask = m; init_start = st;
    exp_rdy = (init_left == 0);
    e = cyc;
    check("req_ready0", W'(ready0), W'(exp_rdy));
    check("req_ready1", W'(ready1), W'(exp_rdy));
    check("init_busy0", W'(busy0), W'(!exp_rdy));
    check("init_busy1", W'(busy1), W'(!exp_rdy));
    if (v && exp_rdy) begin
      if (we) model[a] = (d & ~m) | (model[a] & m);
      else begin
        q0.push_back('{due: e + 1, data: model[a]});
        q1.push_back('{due: e + 2, data: model[a]});
      end
    end
    if (st && exp_rdy) foreach (model[i]) model[i] = INIT_VAL;
    @(posedge clk); #1;
    if (!exp_rdy) init_left--;
    else if (st) init_left = BANK_ROWS;
    req_valid = 1'b0; init_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b1, 1'b0, a, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    drive(1'b1, 1'b1, a, d, m, 1'b0);
  endtask

  // Holds reset for a few cycles checking reset outputs, then releases it.
  task automatic do_reset(input int hold);
    rstb = 1'b0;
    req_valid = 1'b0; init_start = 1'b0;
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0;
    init_left = BANK_ROWS;
    foreach (model[i]) model[i] = INIT_VAL;
    repeat (hold) begin
      @(negedge clk);
      check("rst_rsp_valid0", W'(rv0), '0);
      check("rst_rsp_valid1", W'(rv1), '0);
      check("rst_rsp_data0", rd0, '0);
      check("rst_rsp_data1", rd1, '0);
      check("rst_req_ready0", W'(ready0), '0);
      check("rst_init_busy0", W'(busy0), W'(1));
      check("rst_init_busy1", W'(busy1), W'(1));
    end
    @(posedge clk); #1;
    rstb = 1'b1;
  endtask

  initial begin
    logic [W-1:0] m;
    int           pick;

    // Reset release and the automatic init sweep; writes tried during init are ignored.
    do_reset(3);
    repeat (BANK_ROWS) wr(4'd5, '1, '0);
    idle(1);
    for (int a = 0; a < ROWS; a++) rd(4'(a));
    idle(3);

    // Masked write: full overwrite then keep only the low nibble.
    wr(4'd5, '1, '0);
    wr(4'd5, '0, 32'h0000_000F);
    rd(4'd5);
    idle(3);

    // Back-to-back reads across all banks.
    for (int a = 0; a < 4; a++) wr(4'(a), W'(10 + a), '0);
    for (int a = 0; a < 4; a++) rd(4'(a));
    idle(4);

    // Read in the cycle right after a write to the same row.
    wr(4'd7, 32'hA5, '0);
    rd(4'd7);
    idle(3);

    // Read accepted together with init_start sees the pre-init value.
    wr(4'd3, 32'h33, '0);
    drive(1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    idle(BANK_ROWS);
    rd(4'd3);
    idle(3);

    // Reset in the middle of an init sweep restarts it.
    wr(4'd9, 32'h1234_5678, '0);
    drive(1'b0, 1'b0, 4'd0, '0, '0, 1'b1);
    idle(2);
    do_reset(2);
    idle(BANK_ROWS);
    for (int a = 0; a < ROWS; a++) rd(4'(a));
    idle(3);

    // Random traffic, including requests during init and stray init_start pulses.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 2);
      m = (pick == 0) ? '0 : (pick == 1) ? '1 : W'($urandom);
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
            W'($urandom), m, ($urandom_range(0, 39) == 0));
    end
    idle(5);
    check("queues_drained", W'(q0.size() + q1.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/banked_init_sram.md
Name: banked_init_sram

Overview:
- Parametrised successor to the single-port type-T SRAM behavioural model.
- Splits storage into NUM_BANKS address-interleaved banks and keeps the bit-mask write semantics (mask bit 1 = keep, 0 = overwrite).
- Adds a valid/ready request interface, a fixed-latency read response with an optional output register, and a hardware zero-initialisation sequencer that clears all rows after reset or on demand.
- Sits between accelerator datapaths and on-chip weight/state memories, replacing the bare macro model.

Parameters:
- WIDTH, 128, data/mask width in bits.
- NUM_ROWS, 4096, total rows; must be a multiple of NUM_BANKS.
- NUM_BANKS, 4, number of banks; power of two, ≥1.
- OUT_REG, 0, 1 adds an output pipeline stage (read latency 2 instead of 1).
- INIT_ON_RESET, 1, 1 runs the init sequence automatically on reset release.
- INIT_VALUE, 0, WIDTH-bit value written to every row during init.
- Derived (localparam): AddressWidth=$clog2(NUM_ROWS), BankBits=$clog2(NUM_BANKS), BankRows=NUM_ROWS/NUM_BANKS.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RSTB  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AddressWidth  row address; bank = req_addr[BankBits-1:0], bank row = upper bits.
- req_data  input  WIDTH  write data.
- req_mask  input  WIDTH  write mask (1 keep, 0 overwrite).
- rsp_valid  output  1  one-cycle pulse, read data valid.
- rsp_data  output  WIDTH  read data; holds last read value when rsp_valid=0.
- init_start  input  1  pulse; restarts the clear sequence.
- init_busy  output  1  init sequence in progress.

Behaviour:
- Reset (RSTB=0):
  - rsp_valid=0, rsp_data=0, req_ready=0, read pipeline flushed, init counter=0.
  - init_busy=INIT_ON_RESET; state=INIT if INIT_ON_RESET, else READY.
  - Array contents are not reset.
  - Reset asserted mid-INIT restarts the sequence at row 0.
- FSM:
  - INIT:
    - Each cycle writes INIT_VALUE to bank row init_cnt in all banks in parallel, ignoring mask.
    - init_cnt increments by 1; after writing row BankRows-1, transitions to READY (BankRows cycles total).
    - req_ready=0, init_busy=1.
    - init_start is ignored in INIT.
  - READY:
    - req_ready=1, init_busy=0.
    - init_start=1 moves to INIT next cycle with init_cnt=0.
    - A request presented in the same cycle as init_start is still accepted and executed; init overwrites it afterwards.
- Request acceptance: on posedge with req_valid & req_ready. Only the addressed bank is enabled; all other banks see no access.
- Write: new row = (req_data & ~req_mask) | (old & req_mask). No response is produced.
- Read:
  - rsp_valid=1 exactly 1+OUT_REG cycles after the acceptance edge, with rsp_data = row contents at the acceptance edge.
  - Back-to-back reads give back-to-back responses, one per cycle.
  - No response backpressure.
- Read-after-write to the same address in the next cycle returns the updated data. There is no same-cycle bypass, because only one request is accepted per cycle.
- Reads already accepted when INIT begins still complete with their pre-init data; the read pipeline drains independently of the FSM.
- When rsp_valid=0, rsp_data holds its previous value and does not toggle.
- Address ≥ NUM_ROWS (possible only when NUM_ROWS is not a power of two):
  - Writes are dropped.
  - Reads still produce rsp_valid with rsp_data=0.
- Simulation-only elaboration assertions: NUM_ROWS % NUM_BANKS == 0; NUM_BANKS is a power of two.

Test Plan:
1. Reset release, INIT_ON_RESET=1, NUM_ROWS=16, NUM_BANKS=4 -> init_busy=1 for exactly 4 cycles, req_ready=0 throughout. Reads of all 16 rows afterwards return 0.
2. Write addr 5 data 0xFF..FF mask 0, then write addr 5 data 0 mask 0x0F (low nibble kept), then read addr 5 -> rsp_data = 0x0F in the low byte, other bits 0. rsp_valid arrives 1 cycle after acceptance (OUT_REG=0), 2 cycles with OUT_REG=1.
3. Back-to-back reads of addrs 0,1,2,3 after writing values 10,11,12,13 -> rsp_valid high 4 consecutive cycles with data 10,11,12,13. rsp_data then holds 13.
4. Write addr 7 = 0xA5 and read addr 7 in the very next cycle -> response returns 0xA5.
5. Read addr 3 (value 0x33) accepted in the same cycle as init_start -> response 0x33 delivered. init_busy is high for BankRows cycles from the next cycle; a later read of addr 3 returns INIT_VALUE.
6. RSTB asserted midway through INIT, then released -> init restarts at row 0, rsp_valid=0 during and after reset, and all rows read INIT_VALUE after completion.
